// File: rtl/app_xform.sv
// app_xform: echo application placed between the CDC OUT and IN streams.
// Each accepted OUT byte passes through an escape-sequence parser. It is
// then transformed by the current mode and queued in a DEPTH-entry circular
// buffer, which feeds the IN stream.
//
// Optional feature: define APP_XFORM_LINE_EN to enable line mode. In line
// mode, output is held until a CR/LF is buffered or the buffer is full.
//
// Ports:
//   clk_i        single clock
//   rstn_i       synchronous active-low reset
//   out_data_i   OUT byte from the host side
//   out_valid_i  OUT byte valid
//   out_ready_o  OUT byte accepted when valid & ready (registered)
//   in_data_o    IN byte to the host side (show-ahead buffer head)
//   in_valid_o   IN byte valid
//   in_ready_i   IN byte consumed when valid & ready
//   mode_o       current transform mode
//   count_o      bytes currently buffered
//   sleep_o      idle for SLEEP_CYCLES consecutive cycles
module app_xform #(
  parameter int          DEPTH_LOG2   = 4,
  parameter int          SLEEP_CYCLES = 1024,
  parameter logic [7:0]  ESC_CHAR     = 8'h1B
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [7:0]            out_data_i,
  input  logic                  out_valid_i,
  output logic                  out_ready_o,
  output logic [7:0]            in_data_o,
  output logic                  in_valid_o,
  input  logic                  in_ready_i,
  output logic [1:0]            mode_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  sleep_o
);

  localparam int CW     = DEPTH_LOG2 + 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int IDLE_W = $clog2(SLEEP_CYCLES + 1);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [IDLE_W-1:0] SLEEP_C = IDLE_W'(SLEEP_CYCLES);

  typedef enum logic {ST_DATA, ST_ESC} state_t;

  function automatic logic [7:0] xform(input logic [1:0] m, input logic [7:0] b);
    logic is_lower, is_upper;
    logic [7:0] r;
    is_lower = (b >= 8'h61) && (b <= 8'h7A);
    is_upper = (b >= 8'h41) && (b <= 8'h5A);
    r = b;
    case (m)
      2'd1: begin
        if (is_lower || is_upper)            r = b ^ 8'h20;
        else if (b >= 8'h30 && b <= 8'h38)   r = b + 8'd1;
        else if (b == 8'h39)                 r = 8'h30;
      end
      2'd2: if (is_lower) r = b ^ 8'h20;
      2'd3: if (is_upper) r = b ^ 8'h20;
      default: r = b;
    endcase
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DEPTH_LOG2-1:0]   wr_q, rd_q;
  logic                    out_ready_q;
  logic [IDLE_W-1:0]       idle_q, idle_d;
  logic [7:0]              mem [DEPTH];

  logic       accept, pop, push, rel_ok, idle_cond;
  logic [7:0] push_data;

  assign accept = out_valid_i & out_ready_q;
  assign pop    = in_valid_o & in_ready_i;

  // Parser: decides whether an accepted byte is a command or data.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    push      = 1'b0;
    push_data = xform(mode_q, out_data_i);
    if (accept) begin
      case (state_q)
        ST_DATA: begin
          if (out_data_i == ESC_CHAR) state_d = ST_ESC;
          else                        push    = 1'b1;
        end
        default: begin
          state_d = ST_DATA;
          if (out_data_i >= 8'h30 && out_data_i <= 8'h33) begin
            // '0'..'3' are 0x30..0x33, so the low two bits are the mode.
            mode_d = out_data_i[1:0];
          end else if (out_data_i == ESC_CHAR) begin
            push      = 1'b1;
            push_data = ESC_CHAR;
          end else begin
            push = 1'b1;
          end
        end
      endcase
    end
  end

  assign count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  assign idle_cond = (count_q == '0) & ~out_valid_i & (state_q == ST_DATA);
  assign idle_d    = !idle_cond          ? '0 :
                     (idle_q == SLEEP_C) ? idle_q : idle_q + 1'b1;

`ifdef APP_XFORM_LINE_EN
  logic [CW-1:0] lines_q, lines_d;
  logic          push_term, pop_term;

  assign push_term = push & ((push_data == 8'h0D) | (push_data == 8'h0A));
  assign pop_term  = pop  & ((in_data_o == 8'h0D) | (in_data_o == 8'h0A));
  assign lines_d   = lines_q + {{(CW-1){1'b0}}, push_term} - {{(CW-1){1'b0}}, pop_term};
  // A full buffer always releases so a line longer than DEPTH cannot deadlock.
  assign rel_ok    = (lines_q != '0) | (count_q == DEPTH_C);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) lines_q <= '0;
    else         lines_q <= lines_d;
  end
`else
  assign rel_ok = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= ST_DATA;
      mode_q      <= 2'd0;
      count_q     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      out_ready_q <= 1'b0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      // Looking at the next count keeps ready low in any cycle where the
      // buffer holds DEPTH bytes, so a push can never overrun it.
      out_ready_q <= (count_d < DEPTH_C);
      idle_q      <= idle_d;
    end
  end

  // Buffer storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= push_data;
  end

  assign in_data_o   = mem[rd_q];
  assign in_valid_o  = (count_q != '0) & rel_ok;
  assign out_ready_o = out_ready_q;
  assign mode_o      = mode_q;
  assign count_o     = count_q;
  assign sleep_o     = (idle_q == SLEEP_C);

endmodule

// File: tb/tb_app_xform.sv
// Testbench for app_xform. Directed stimulus pushes expected IN bytes into
// a queue, and a monitor pops and compares each byte the DUT hands over.
module tb_app_xform;

  localparam int DL2 = 4;

  logic           clk = 1'b0;
  logic           rstn_i;
  logic [7:0]     out_data_i;
  logic           out_valid_i;
  logic           out_ready_o;
  logic [7:0]     in_data_o;
  logic           in_valid_o;
  logic           in_ready_i;
  logic [1:0]     mode_o;
  logic [DL2:0]   count_o;
  logic           sleep_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  app_xform #(.DEPTH_LOG2(DL2), .SLEEP_CYCLES(8), .ESC_CHAR(8'h1B)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .mode_o(mode_o), .count_o(count_o), .sleep_o(sleep_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: compares every byte consumed on the IN side against the queue.
  always begin
    @(negedge clk);
    #2;
    if (rstn_i && in_valid_o && in_ready_i) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL in_data: unexpected byte 0x%02h, none expected", in_data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (in_data_o == e) begin
          pass_cnt++;
          $display("tb: popped 0x%02h ok", in_data_o);
        end else begin
          $display("FAIL in_data: got 0x%02h expected 0x%02h", in_data_o, e);
        end
      end
    end
  end

  // Offer one byte starting at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b, input bit exp_en, input logic [7:0] exp_b);
    int n;
    out_data_i  = b;
    out_valid_i = 1'b1;
    n = 0;
    while (!out_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_ready_o) begin
      total_cnt++;
      $display("FAIL send_timeout: byte 0x%02h not accepted, out_ready_o=%0d required 1", b, out_ready_o);
      out_valid_i = 1'b0;
      return;
    end
    if (exp_en) exp_q.push_back(exp_b);
    @(negedge clk);
    out_valid_i = 1'b0;
    $display("tb: sent 0x%02h", b);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rstn_i = 1'b0; out_data_i = 8'h00; out_valid_i = 1'b0; in_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_ready", out_ready_o, 0);
    chk("rst_in_valid",  in_valid_o, 0);
    chk("rst_mode",      mode_o, 0);
    chk("rst_count",     count_o, 0);
    chk("rst_sleep",     sleep_o, 0);
    rstn_i = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", out_ready_o, 1);

    // Mode 0 streaming, with no same-cycle bypass on an empty buffer.
    in_ready_i = 1'b1;
    chk("no_bypass", in_valid_o, 0);
    send("a", 1, "a");
    chk("latency_valid", in_valid_o, 1);
    send("Z", 1, "Z");
    send("5", 1, "5");
    chk("stream_sleep", sleep_o, 0);
    drain("drain_stream");

    // Mode 1: the command emits nothing.
    send(8'h1B, 0, 0);
    send("1", 0, 0);
    chk("mode1", mode_o, 1);
    chk("cmd_no_output", count_o, 0);
    send("a", 1, "A");
    send("Z", 1, "z");
    send("8", 1, "9");
    send("9", 1, "0");
    send("!", 1, "!");
    drain("drain_mode1");

    // Mode 2 with escaped ESC and a dropped escape.
    send(8'h1B, 0, 0);
    send("2", 0, 0);
    chk("mode2", mode_o, 2);
    send(8'h1B, 0, 0);
    send(8'h1B, 1, 8'h1B);
    send("q", 1, "Q");
    send(8'h1B, 0, 0);
    send("x", 1, "X");
    drain("drain_mode2");

    // Mode 3 lowercases only upper case letters.
    send(8'h1B, 0, 0);
    send("3", 0, 0);
    send("M", 1, "m");
    send("m", 1, "m");
    send(8'h1B, 0, 0);
    send("0", 0, 0);
    chk("mode0", mode_o, 0);
    drain("drain_mode3");

    // Fill the buffer with the sink stalled; the write pointer wraps.
    in_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) send(8'h41 + 8'(i), 1, 8'h41 + 8'(i));
    chk("full_count", count_o, 16);
    chk("full_ready", out_ready_o, 0);
    @(negedge clk);
    chk("full_ready_hold", out_ready_o, 0);
    in_ready_i = 1'b1;
    @(negedge clk);
    in_ready_i = 1'b0;
    chk("after_pop_count", count_o, 15);
    chk("after_pop_ready", out_ready_o, 1);
    in_ready_i = 1'b1;
    drain("drain_full");

    // Idle: sleep asserts, then clears the edge after out_valid_i rises.
    n = 0;
    while (!sleep_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("sleep_set", sleep_o, 1);
    send("k", 1, "k");
    chk("sleep_clear", sleep_o, 0);
    drain("drain_idle");

    // Reset mid-operation with bytes buffered, mode 1 and an escape pending.
    in_ready_i = 1'b0;
    send(8'h1B, 0, 0);
    send("1", 0, 0);
    send("a", 0, 0);
    send("b", 0, 0);
    send("c", 0, 0);
    send(8'h1B, 0, 0);
    chk("pre_rst_count", count_o, 3);
    chk("pre_rst_mode", mode_o, 1);
    rstn_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_mode", mode_o, 0);
    chk("mid_rst_valid", in_valid_o, 0);
    chk("mid_rst_ready", out_ready_o, 0);
    rstn_i = 1'b1;
    in_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", in_valid_o, 0);
    send("3", 1, "3");
    drain("drain_post_rst");

`ifdef APP_XFORM_LINE_EN
    send("a", 1, "a");
    send("b", 1, "b");
    repeat (3) @(negedge clk);
    chk("line_hold", in_valid_o, 0);
    send(8'h0D, 1, 8'h0D);
    drain("drain_line");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
